// File: rtl/mult_pkg.sv
// Shared constants, issue-mode enum and the extend-and-multiply helper
// used by the pipelined multiplier.
package mult_pkg;

  localparam int LATENCY_MIN = 2;
  localparam int LATENCY_MAX = 8;
  localparam int OP_MAX      = 32;

  typedef enum logic {
    ISSUE_LEVEL = 1'b0,
    ISSUE_EDGE  = 1'b1
  } issue_mode_e;

  // Operands arrive zero-extended to OP_MAX; only the low `width` bits are meaningful.
  // The low 2*width bits of the returned product are exact in both modes.
  function automatic logic [2*OP_MAX-1:0] prod_ext(
    input logic [OP_MAX-1:0] a,
    input logic [OP_MAX-1:0] b,
    input logic              sgn,
    input int                width
  );
    logic [2*OP_MAX-1:0] a_ext;
    logic [2*OP_MAX-1:0] b_ext;
    logic [2*OP_MAX-1:0] hi_mask;
    hi_mask = ~((64'd1 << width) - 64'd1);
    a_ext   = 64'(a);
    b_ext   = 64'(b);
    if (sgn && a[width-1]) a_ext = a_ext | hi_mask;
    if (sgn && b[width-1]) b_ext = b_ext | hi_mask;
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Parametrised {valid, data} shift register; only the valid bits are reset.
// DEPTH=0 collapses to straight wires.
module pipe_delay #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          dly_valid,
  output logic [DW-1:0] dly_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dly_valid = src_valid;
      assign dly_data  = src_data;
    end else begin : g_shift
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic          valid_reg;
        logic [DW-1:0] data_reg;
        logic          prev_valid;
        logic [DW-1:0] prev_data;

        if (gi == 0) begin : g_head
          assign prev_valid = src_valid;
          assign prev_data  = src_data;
        end else begin : g_link
          assign prev_valid = g_stage[gi-1].valid_reg;
          assign prev_data  = g_stage[gi-1].data_reg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) valid_reg <= 1'b0;
          else        valid_reg <= prev_valid;
        end

        // Data only moves with a valid token so bubbles leave it untouched.
        always_ff @(posedge clk) begin
          if (prev_valid) data_reg <= prev_data;
        end
      end

      assign dly_valid = g_stage[DEPTH-1].valid_reg;
      assign dly_data  = g_stage[DEPTH-1].data_reg;
    end
  endgenerate

endmodule

// File: rtl/pipe_mult.sv
// Pipelined WIDTH x WIDTH multiplier with configurable latency and issue mode.
// Signed operation is built only when PIPE_MULT_SIGNED_EN is defined.
module pipe_mult
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 3,
  parameter int EDGE_START = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_op,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic [3:0]         in_flight
);

  localparam int          PW         = 2 * WIDTH;
  localparam issue_mode_e ISSUE_MODE = (EDGE_START != 0) ? ISSUE_EDGE : ISSUE_LEVEL;

  generate
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("pipe_mult: LATENCY must be in 2..8");
    end
    if (WIDTH < 1 || WIDTH > OP_MAX) begin : g_bad_width
      $error("pipe_mult: WIDTH must be in 1..32");
    end
  endgenerate

  logic issue;

  generate
    if (ISSUE_MODE == ISSUE_EDGE) begin : g_edge
      logic start_q_reg;
      // Resets high so a start held across reset release is not an edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_q_reg <= 1'b1;
        else        start_q_reg <= start;
      end
      assign issue = start & ~start_q_reg;
    end else begin : g_level
      assign issue = start;
    end
  endgenerate

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             valid0_reg;
  logic             sgn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      valid0_reg <= 1'b0;
    end else begin
      valid0_reg <= issue;
      if (issue) begin
        a_reg <= A;
        b_reg <= B;
      end
    end
  end

`ifdef PIPE_MULT_SIGNED_EN
  logic sgn_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sgn_reg <= 1'b0;
    else if (issue) sgn_reg <= signed_op;
  end
  assign sgn = sgn_reg;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn              = 1'b0;
`endif

  logic [PW-1:0] prod_next;
  logic [PW-1:0] p1_reg;
  logic          valid1_reg;

  assign prod_next = PW'(prod_ext(OP_MAX'(a_reg), OP_MAX'(b_reg), sgn, WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_reg     <= '0;
      valid1_reg <= 1'b0;
    end else begin
      valid1_reg <= valid0_reg;
      if (valid0_reg) p1_reg <= prod_next;
    end
  end

  logic          last_valid;
  logic [PW-1:0] last_data;

  pipe_delay #(
    .DEPTH (LATENCY - 2),
    .DW    (PW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (valid1_reg),
    .src_data  (p1_reg),
    .dly_valid (last_valid),
    .dly_data  (last_data)
  );

  logic [PW-1:0] result_reg;
  logic [3:0]    in_flight_reg;
  logic [3:0]    in_flight_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          result_reg <= '0;
    else if (last_valid) result_reg <= last_data;
  end

  // Counting issues in and completions out tracks the popcount of the stage valids.
  always_comb begin
    in_flight_next = in_flight_reg + {3'b000, issue} - {3'b000, last_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_flight_reg <= 4'd0;
    else        in_flight_reg <= in_flight_next;
  end

  assign done      = last_valid;
  assign result    = last_valid ? last_data : result_reg;
  assign busy      = (in_flight_reg != 4'd0);
  assign in_flight = in_flight_reg;

endmodule

// File: tb/tb_pipe_mult.sv
// Scoreboard bench for pipe_mult: four instances covering edge/level issue,
// latencies 2/3/4/8 and widths 8/16; signed expectations follow PIPE_MULT_SIGNED_EN.
module tb_pipe_mult;

`ifdef PIPE_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [3:0]  start_v = '0;
  logic [3:0]  sop_v   = '0;
  logic [7:0]  a8  [2];
  logic [7:0]  b8  [2];
  logic [15:0] a16 [2];
  logic [15:0] b16 [2];

  wire [3:0]  done_v;
  wire [3:0]  busy_v;
  wire [3:0]  inf   [4];
  wire [15:0] res8  [2];
  wire [31:0] res16 [2];

  pipe_mult #(.WIDTH(8), .LATENCY(3), .EDGE_START(1)) u_e3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(a8[0]), .B(b8[0]),
    .signed_op(sop_v[0]), .done(done_v[0]), .result(res8[0]),
    .busy(busy_v[0]), .in_flight(inf[0]));

  pipe_mult #(.WIDTH(8), .LATENCY(4), .EDGE_START(0)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(a8[1]), .B(b8[1]),
    .signed_op(sop_v[1]), .done(done_v[1]), .result(res8[1]),
    .busy(busy_v[1]), .in_flight(inf[1]));

  pipe_mult #(.WIDTH(16), .LATENCY(2), .EDGE_START(1)) u_e2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .A(a16[0]), .B(b16[0]),
    .signed_op(sop_v[2]), .done(done_v[2]), .result(res16[0]),
    .busy(busy_v[2]), .in_flight(inf[2]));

  pipe_mult #(.WIDTH(16), .LATENCY(8), .EDGE_START(1)) u_e8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .A(a16[1]), .B(b16[1]),
    .signed_op(sop_v[3]), .done(done_v[3]), .result(res16[1]),
    .busy(busy_v[3]), .in_flight(inf[3]));

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] res_of(input int i);
    if (i < 2) return {16'd0, res8[i]};
    return res16[i-2];
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 3;
      1:       return 4;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    if (i < 2) begin
      a8[i] = a[7:0];
      b8[i] = b[7:0];
    end else begin
      a16[i-2] = a;
      b16[i-2] = b;
    end
    sop_v[i] = s;
  endtask

  // Driven just after a falling edge, so the issue edge is the next rising edge
  // and done is expected LATENCY-1 rising edges after that one.
  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] want);
    set_ops(i, a, b, s);
    start_v[i] = 1'b1;
    sb.push_back('{inst: i, due: cyc + lat_of(i), val: want});
    $display("issue inst=%0d a=%0h b=%0h s=%0b want=%0h due=%0d", i, a, b, s, want, cyc + lat_of(i));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (done_v[i]) begin
          if (sb.size() == 0 || sb[0].inst != i) begin
            check_val($sformatf("spurious_done_i%0d", i), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            $display("done inst=%0d result=%0h want=%0h cycle=%0d due=%0d", i, res_of(i), e.val, cyc, e.due);
            check_val($sformatf("result_i%0d", i), res_of(i), e.val);
            check_val($sformatf("latency_i%0d", i), cyc, e.due);
          end
        end
      end
      if (sb.size() != 0 && cyc > sb[0].due) begin
        check_val($sformatf("missed_done_i%0d", sb[0].inst), 32'd0, 32'd1);
        sb.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  t3_a  [4] = '{8'hFF, 8'h80, 8'hFF, 8'h80};
  logic [7:0]  t3_b  [4] = '{8'hFF, 8'h7F, 8'hFF, 8'h7F};
  logic        t3_s  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] t3_sg [4] = '{16'h0001, 16'hC080, 16'hFE01, 16'h3F80};
  logic [15:0] t3_us [4] = '{16'hFE01, 16'h3F80, 16'hFE01, 16'h3F80};

  initial begin
    for (int i = 0; i < 2; i++) begin
      a8[i] = '0; b8[i] = '0; a16[i] = '0; b16[i] = '0;
    end

    // Reset state
    #2;
    check_val("rst_done", {31'd0, done_v[0]}, 32'd0);
    check_val("rst_result", res_of(0), 32'd0);
    check_val("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    check_val("rst_in_flight", {28'd0, inf[0]}, 32'd0);
    check_val("rst_result_i3", res_of(3), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(3);

    // Edge mode, start held 5 cycles: one issue only
    issue(0, 16'd255, 16'd255, 1'b0, 32'hFE01);
    for (int j = 1; j <= 5; j++) begin
      step(1);
      check_val("t1_busy", {31'd0, busy_v[0]}, (j <= 3) ? 32'd1 : 32'd0);
      check_val("t1_in_flight", {28'd0, inf[0]}, (j <= 3) ? 32'd1 : 32'd0);
    end
    start_v[0] = 1'b0;
    step(2);

    // Level mode, three back-to-back issues
    issue(1, 16'd3, 16'd5, 1'b0, 32'd15);
    step(1);
    issue(1, 16'd7, 16'd9, 1'b0, 32'd63);
    step(1);
    issue(1, 16'd16, 16'd16, 1'b0, 32'd256);
    step(1);
    start_v[1] = 1'b0;
    check_val("t2_in_flight_peak", {28'd0, inf[1]}, 32'd3);
    step(6);
    check_val("t2_result_hold", res_of(1), 32'd256);
    check_val("t2_done_low", {31'd0, done_v[1]}, 32'd0);
    check_val("t2_in_flight_end", {28'd0, inf[1]}, 32'd0);

    // Signed/unsigned products
    for (int k = 0; k < 4; k++) begin
      issue(0, {8'd0, t3_a[k]}, {8'd0, t3_b[k]}, t3_s[k],
            {16'd0, (SIGNED_EN && t3_s[k]) ? t3_sg[k] : t3_us[k]});
      step(1);
      start_v[0] = 1'b0;
      step(1);
    end
    step(4);

    // Latency extremes at WIDTH=16
    issue(2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    step(1);
    start_v[2] = 1'b0;
    issue(3, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    step(1);
    start_v[3] = 1'b0;
    step(10);
    check_val("t6_result_i2", res_of(2), 32'hFFFE0001);
    check_val("t6_result_i3", res_of(3), 32'hFFFE0001);

    // Operand isolation: inputs churn with no issue
    issue(0, 16'd2, 16'd3, 1'b0, 32'd6);
    step(1);
    start_v[0] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      set_ops(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0);
      step(1);
    end
    for (int j = 0; j < 10; j++) begin
      check_val("t5_result_hold", res_of(0), 32'd6);
      set_ops(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0);
      step(1);
    end

    // Reset mid-flight: operation is discarded, no done afterward
    set_ops(0, 16'd10, 16'd10, 1'b0);
    start_v[0] = 1'b1;
    $display("issue inst=0 a=a b=a (discarded by reset)");
    step(2);
    check_val("t4_busy_before", {31'd0, busy_v[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t4_done_rst", {31'd0, done_v[0]}, 32'd0);
    check_val("t4_result_rst", res_of(0), 32'd0);
    check_val("t4_busy_rst", {31'd0, busy_v[0]}, 32'd0);
    check_val("t4_in_flight_rst", {28'd0, inf[0]}, 32'd0);
    step(2);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step(1);
      check_val("t4_no_done", {31'd0, done_v[0]}, 32'd0);
      check_val("t4_in_flight_idle", {28'd0, inf[0]}, 32'd0);
    end
    start_v[0] = 1'b0;
    step(3);

    check_val("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_mult.md
Name: pipe_mult

Overview:
- Parametrised pipelined multiplier for the TinyALU multiply path.
- Next generation of the fixed 8x8, three-cycle multiplier, adding:
  - configurable operand width and latency
  - edge or level issue mode
  - operand capture only on issue
  - result hold between operations
  - busy and in-flight reporting
- Sits between the ALU operand registers and the result mux; `done` feeds the ALU done logic.

Parameters:
- WIDTH, 8: operand width in bits; result is 2*WIDTH.
- LATENCY, 3: clock edges from the issue edge to `done` high; legal range 2..8, with an elaboration error outside it.
- EDGE_START, 1: 1 issues on the rising edge of `start` only; 0 issues on every cycle `start` is high.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request, edge or level per EDGE_START
- A  input  WIDTH  operand A, sampled on issue only
- B  input  WIDTH  operand B, sampled on issue only
- signed_op  input  1  treat A/B as two's complement; sampled on issue
- done  output  1  one-cycle pulse, result valid
- result  output  2*WIDTH  product; holds until the next done
- busy  output  1  any operation in flight
- in_flight  output  4  count of operations in the pipeline (0..LATENCY)

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low. All flops clear on reset assertion with no clock required.
- Reset values:
  - done=0, result=0, busy=0, in_flight=0
  - all stage valid bits 0
  - start_q=1, so `start` held high across reset release does NOT issue
- Issue condition (evaluated each cycle):
  - EDGE_START=1: issue = start & ~start_q, where start_q is start registered every cycle.
  - EDGE_START=0: issue = start.
- Stage 0, on an issue edge: register A, B and signed_op, and set valid0. Operand registers hold when there is no issue.
- Stage 1: product computed from the stage-0 registers.
  - Unsigned: zero-extend both operands to 2*WIDTH and multiply.
  - Signed: sign-extend both operands to 2*WIDTH and multiply.
  - Keep the low 2*WIDTH bits; the result is exact in both modes.
- Stages 2..LATENCY-1: pass product and valid through unchanged.
- Latency and throughput:
  - An issue sampled at edge t gives done=1 for the cycle after edge t+LATENCY-1, i.e. exactly LATENCY edges from issue.
  - Throughput is one issue per cycle, so back-to-back issues give back-to-back done pulses in issue order.
- Result: loads only when the final-stage valid is 1, and holds otherwise. Bubbles never disturb `result`.
- done: equals the final-stage valid. Never high for two cycles unless two issues occurred.
- busy: OR of all stage valids. in_flight: registered popcount of the stage valids.
- Simultaneous issue and done in one cycle: both are honoured, and in_flight is unchanged.
- Reset mid-operation: all in-flight operations are discarded and no done follows reset release.
- Bounds: in_flight never exceeds LATENCY. No full or empty stall exists; the pipeline never back-pressures.

Optional Feature:
- Macro: PIPE_MULT_SIGNED_EN.
- Defined: signed_op selects signed or unsigned multiplication as above.
- Undefined:
  - signed_op is ignored, not registered, and all products are unsigned.
  - The port remains, for a stable interface.
  - Synthesis removes the sign-extension logic.

Decomposition:
- Package mult_pkg:
  - LATENCY_MIN=2, LATENCY_MAX=8
  - typedef issue_mode_e {ISSUE_LEVEL, ISSUE_EDGE}
  - function `prod_ext` performing signed/unsigned extension and multiply, parametrised through the WIDTH argument
- Sub-module pipe_delay: parametrised shift register of {valid, data}.
  - Parameters: DEPTH, DW.
  - Async active-low reset of the valid bits only.
  - Instantiated for stages 2..LATENCY-1 with DEPTH=LATENCY-2; degenerates to wires at DEPTH=0.

Test Plan:
1. WIDTH=8, LATENCY=3, edge mode: A=255, B=255, start rises at edge 0 and is held 5 cycles.
   - Required: exactly one done, at edge 3, with result=16'hFE01.
   - Required: busy high for cycles 1..3 and in_flight peaking at 1.
2. Level mode, LATENCY=4: issue (3,5), (7,9), (16,16) on consecutive cycles.
   - Required: done high for 3 consecutive cycles with results 15, 63, 256 in order.
   - Required: in_flight reaching 3, and result held at 256 afterward.
3. PIPE_MULT_SIGNED_EN defined, signed_op=1: (8'hFF, 8'hFF) gives 16'h0001, and (8'h80, 8'h7F) gives 16'hC080.
   - Same operands with signed_op=0 give 16'hFE01 and 16'h3F80.
   - Macro undefined with signed_op=1: (8'hFF, 8'hFF) gives 16'hFE01.
4. Reset mid-flight: issue (10,10), then assert rst_n=0 one cycle later, asynchronously between edges.
   - Required: done, result, busy and in_flight drop to 0 immediately.
   - Required: no done within 10 cycles after release while start is held high.
5. Operand isolation: issue (2,3), then change A/B every cycle with no issue.
   - Required: result=6, and it stays 6 for 10 cycles with no further done.
6. LATENCY=2 and LATENCY=8, WIDTH=16: issue 16'hFFFF x 16'hFFFF.
   - Required: done at exactly 2 and 8 edges respectively, with result=32'hFFFE0001.
